prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter ADDR_W, default 5: width of program counter and mem_addr.
REQ-002 Parameter LONG_CYCLES, default 3: EXEC cycles per ALU-class instruction; legal range 2..15.
REQ-003 Parameter SHORT_CYCLES, default 1: EXEC cycles per move-class instruction; legal range 1..15.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  reset, synchronous and active-low.
REQ-006 run  input  1  level request to start or continue program execution.
REQ-007 mem_data  input  16  instruction word from synchronous program memory, valid one cycle after mem_addr.
REQ-008 mem_addr  output  ADDR_W  program memory read address, registered.
REQ-009 iin  output  16  instruction word driven to the processor datapath, registered.
REQ-010 proc_resetn  output  1  active-low hold to the processor control unit; high only while an instruction executes.
REQ-011 busy  output  1  high in FETCH, LOAD, EXEC.
REQ-012 done  output  1  high in HALT.
REQ-013 pc  output  ADDR_W  current program counter.

Function
REQ-014 FSM states: IDLE, FETCH, LOAD, EXEC, HALT; encoding free.
REQ-015 IDLE: proc_resetn=0, busy=0, done=0; run=1 -> FETCH next cycle.
REQ-016 FETCH, one cycle: mem_addr<=pc; -> LOAD.
REQ-017 LOAD, one cycle: ir<=mem_data; iin<=mem_data; exec counter<=cycle count of that word; if mem_data[15:13]=3'b111 -> HALT, else -> EXEC.
REQ-018 Cycle count: opcode mem_data[15:13] in {000,001} -> SHORT_CYCLES; opcode in {010..110} -> LONG_CYCLES.
REQ-019 EXEC: proc_resetn=1, iin held stable, counter decrements each cycle; on the cycle the counter equals 1, pc<=pc+1 and next state is FETCH if run=1, else IDLE.
REQ-020 run falling during EXEC does not abort; the current instruction completes its full cycle count before IDLE.
REQ-021 run falling during FETCH or LOAD -> IDLE next cycle, pc unchanged.
REQ-022 pc wraps: pc=2^ADDR_W-1 incremented -> 0; no error flag.
REQ-023 HALT: done=1, busy=0, proc_resetn=0, pc unchanged (points at halt word); run=0 -> IDLE; run=1 -> remain in HALT.
REQ-024 Leaving HALT or IDLE never increments pc; restart resumes at the held pc.
REQ-025 iin holds its last value in IDLE, FETCH and HALT; updates only in LOAD.
REQ-026 Instruction throughput: 2 + N cycles per instruction (FETCH + LOAD + N EXEC), no overlap.

Reset
REQ-027 resetn=0 at a rising edge, in any state -> next state IDLE, pc=0, mem_addr=0, iin=0, ir=0, exec counter=0, proc_resetn=0, busy=0, done=0.
REQ-028 resetn low mid-EXEC aborts the instruction immediately; pc is not incremented.
REQ-029 resetn has priority over run and over every state transition.

Verification
REQ-030 Reset then run=1, mem[0]=16'h2000 (mvi), mem[1]=16'hE000 -> mem_addr=0 at cycle 1, iin=16'h2000 at cycle 2, proc_resetn=1 for exactly 1 cycle, pc=1, then HALT with done=1, pc=1.
REQ-031 mem[0]=16'h4000 (add), LONG_CYCLES=3 -> proc_resetn high exactly 3 consecutive cycles, iin stable throughout, pc 0->1 on the last.
REQ-032 run dropped in 2nd EXEC cycle of a 3-cycle instruction -> 3rd cycle still executes, then IDLE with pc=1; run reasserted -> FETCH at mem_addr=1.
REQ-033 pc=31 (ADDR_W=5), mem[31]=16'h0000 -> after execution pc=0, next mem_addr=0.
REQ-034 resetn=0 asserted in EXEC at pc=4 -> next cycle pc=0, iin=0, proc_resetn=0, busy=0, state IDLE.
REQ-035 In HALT with run=1 held 10 cycles -> done stays 1, mem_addr and pc unchanged; run=0 -> done=0 next cycle.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches instruction words from program memory and gates the
// processor through a fixed number of EXEC cycles per opcode class.
module prog_sequencer #(
    parameter int ADDR_W       = 5,
    parameter int LONG_CYCLES  = 3,
    parameter int SHORT_CYCLES = 1
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    input  logic              i_run,
    input  logic [15:0]       i_mem_data,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_iin,
    output logic              o_proc_resetn,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_pc
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_HALT} state_t;
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_ir;
    logic              r_proc_resetn;
    logic              r_busy;
    logic              r_done;
    logic              w_halt;
    logic [3:0]        w_cycles;
    logic              w_last;
    assign w_halt   = i_mem_data[15:13] == 3'b111;
    assign w_cycles = (i_mem_data[15:14] == 2'b00) ? 4'(SHORT_CYCLES) : 4'(LONG_CYCLES);
    assign w_last   = r_cnt == 4'd1;
    // Status outputs are written with the state they describe, so they stay aligned with r_state.
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_pc          <= '0;
            r_mem_addr    <= '0;
            r_ir          <= '0;
            r_proc_resetn <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_run) begin
                    r_state <= S_FETCH;
                    r_busy  <= 1'b1;
                end
                S_FETCH: begin
                    r_mem_addr <= r_pc;
                    r_state    <= i_run ? S_LOAD : S_IDLE;
                    r_busy     <= i_run;
                end
                S_LOAD: if (!i_run) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end else begin
                    r_ir          <= i_mem_data;
                    r_cnt         <= w_cycles;
                    r_state       <= w_halt ? S_HALT : S_EXEC;
                    r_proc_resetn <= !w_halt;
                    r_busy        <= !w_halt;
                    r_done        <= w_halt;
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_last) begin
                        r_pc          <= r_pc + 1'b1;
                        r_proc_resetn <= 1'b0;
                        r_state       <= i_run ? S_FETCH : S_IDLE;
                        r_busy        <= i_run;
                    end
                end
                S_HALT: if (!i_run) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_proc_resetn <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                end
            endcase
        end
    end
    assign o_mem_addr    = r_mem_addr;
    assign o_iin         = r_ir;
    assign o_proc_resetn = r_proc_resetn;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_pc          = r_pc;
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed vector table plus hand sequences for the
// run-drop, pc-wrap, mid-EXEC reset and HALT-hold corner cases.
module tb_prog_sequencer;
    logic        clk = 1'b0;
    logic        resetn;
    logic        run;
    logic [15:0] mem_data;
    logic [4:0]  mem_addr;
    logic [15:0] iin;
    logic        proc_resetn;
    logic        busy;
    logic        done;
    logic [4:0]  pc;
    logic [15:0] mem [32];
    int          n_cmp = 0;
    int          n_err = 0;

    prog_sequencer #(.ADDR_W(5), .LONG_CYCLES(3), .SHORT_CYCLES(1)) dut (
        .i_clock(clk), .i_resetn(resetn), .i_run(run), .i_mem_data(mem_data),
        .o_mem_addr(mem_addr), .o_iin(iin), .o_proc_resetn(proc_resetn),
        .o_busy(busy), .o_done(done), .o_pc(pc)
    );

    always #5 clk = ~clk;
    assign mem_data = mem[mem_addr];

    typedef struct {
        logic        run;
        logic [4:0]  ma;
        logic [15:0] iin;
        logic        pr;
        logic        busy;
        logic        done;
        logic [4:0]  pc;
    } vec_t;
    vec_t tv [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {3'b0, mem_addr, iin, proc_resetn, busy, done, pc};
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        run    = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    endtask

    initial begin
        tv[0]  = '{1, 0, 16'h0000, 0, 1, 0, 0};
        tv[1]  = '{1, 0, 16'h0000, 0, 1, 0, 0};
        tv[2]  = '{1, 0, 16'h2000, 1, 1, 0, 0};
        tv[3]  = '{1, 0, 16'h2000, 0, 1, 0, 1};
        tv[4]  = '{1, 1, 16'h2000, 0, 1, 0, 1};
        tv[5]  = '{1, 1, 16'h4000, 1, 1, 0, 1};
        tv[6]  = '{1, 1, 16'h4000, 1, 1, 0, 1};
        tv[7]  = '{1, 1, 16'h4000, 1, 1, 0, 1};
        tv[8]  = '{1, 1, 16'h4000, 0, 1, 0, 2};
        tv[9]  = '{1, 2, 16'h4000, 0, 1, 0, 2};
        tv[10] = '{1, 2, 16'hE000, 0, 0, 1, 2};
        tv[11] = '{1, 2, 16'hE000, 0, 0, 1, 2};
        tv[12] = '{0, 2, 16'hE000, 0, 0, 0, 2};

        clear_mem();
        mem[0] = 16'h2000;
        mem[1] = 16'h4000;
        mem[2] = 16'hE000;
        do_reset();
        chk("reset_state", obs(), 32'h0);
        for (int i = 0; i < 13; i++) begin
            run = tv[i].run;
            tick();
            chk($sformatf("vec%0d", i), obs(),
                {3'b0, tv[i].ma, tv[i].iin, tv[i].pr, tv[i].busy, tv[i].done, tv[i].pc});
        end

        // run dropped in the 2nd EXEC cycle of a 3-cycle add
        clear_mem();
        mem[0] = 16'h4000;
        mem[1] = 16'hE000;
        do_reset();
        run = 1'b1;
        tick();
        tick();
        tick();
        tick();
        run = 1'b0;
        tick();
        chk("drop_exec3_pr", {31'b0, proc_resetn}, 32'd1);
        chk("drop_exec3_pc", {27'b0, pc}, 32'd0);
        tick();
        chk("drop_idle", {29'b0, proc_resetn, busy, done}, 32'b000);
        chk("drop_idle_pc", {27'b0, pc}, 32'd1);
        run = 1'b1;
        tick();
        chk("resume_fetch_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("resume_load_ma", {27'b0, mem_addr}, 32'd1);

        // pc wrap across a program of 1-cycle moves
        clear_mem();
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 94; i++) tick();
        chk("wrap_pc31", {27'b0, pc}, 32'd31);
        tick();
        tick();
        chk("wrap_exec_ma31", {27'b0, mem_addr}, 32'd31);
        tick();
        chk("wrap_pc0", {27'b0, pc}, 32'd0);
        tick();
        chk("wrap_ma0", {27'b0, mem_addr}, 32'd0);

        // reset asserted mid-EXEC at pc=4, with run still high
        clear_mem();
        mem[4] = 16'h1234;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("pre_rst_exec", {11'b0, pc, iin}, {11'b0, 5'd4, 16'h1234});
        chk("pre_rst_pr", {31'b0, proc_resetn}, 32'd1);
        resetn = 1'b0;
        tick();
        chk("mid_rst", obs(), 32'h0);
        resetn = 1'b1;
        run = 1'b0;

        // HALT held with run=1 for 10 cycles
        clear_mem();
        mem[1] = 16'hE000;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("halt_hold%0d", i), {27'b0, mem_addr, busy, done, pc},
                {27'b0, 5'd1, 1'b0, 1'b1, 5'd1});
        end
        run = 1'b0;
        tick();
        chk("halt_exit_done", {31'b0, done}, 32'd0);
        chk("halt_exit_pc", {27'b0, pc}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
